// File: rtl/qar_dmem_bridge.sv
// ============================================================================
// Module      : qar_dmem_bridge
// Description : Core mem_* valid/ready port to 1-cycle-latency single-port
//               SRAM bridge with wait states and address-error responses.
//               Optional counters: define QAR_DMEM_BRIDGE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qar_dmem_bridge #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned SRAM_AW     = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_valid,
    input  logic               mem_we,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    output logic               mem_ready,
    output logic [31:0]        mem_rdata,
    output logic               mem_err,
    output logic               sram_en,
    output logic               sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata,
    output logic [15:0]        stat_reads,
    output logic [15:0]        stat_writes,
    output logic [15:0]        stat_errs
);

    localparam logic       HAS_WAIT  = (WAIT_STATES != 0);
    localparam logic [3:0] WAIT_INIT = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_ACCESS = 3'd2,
        S_RESP   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               lat_we;
    logic [SRAM_AW-1:0] lat_addr;
    logic [31:0]        lat_wdata;
    logic [3:0]         wcnt;
    logic [31:0]        rdata_q;

    logic [31:0]        off;
    logic               bad;
    logic               src_we;
    logic [SRAM_AW-1:0] src_addr;
    logic [31:0]        src_wdata;

    assign off = mem_addr - BASE_ADDR;
    assign bad = (mem_addr[1:0] != 2'b00) ||
                 (mem_addr < BASE_ADDR) ||
                 ({2'b00, off[31:2]} >= 32'(DEPTH_WORDS));

    // With no wait states ACCESS follows IDLE directly, so the SRAM fields
    // must come from the live request rather than the latch being loaded.
    always_comb begin
        src_we    = lat_we;
        src_addr  = lat_addr;
        src_wdata = lat_wdata;
        if (state == S_IDLE) begin
            src_we    = mem_we;
            src_addr  = off[SRAM_AW+1:2];
            src_wdata = mem_wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (mem_valid) begin
                    if (bad)
                        state_nxt = S_ERR;
                    else if (HAS_WAIT)
                        state_nxt = S_WAIT;
                    else
                        state_nxt = S_ACCESS;
                end
            end
            S_WAIT: begin
                if (wcnt == 4'd0)
                    state_nxt = S_ACCESS;
            end
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            S_ERR:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are valid during the
    // cycle the FSM spends in that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            wcnt       <= 4'd0;
            rdata_q    <= '0;
            mem_ready  <= 1'b0;
            mem_err    <= 1'b0;
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            state <= state_nxt;

            if (state == S_IDLE && mem_valid) begin
                lat_we    <= mem_we;
                lat_addr  <= off[SRAM_AW+1:2];
                lat_wdata <= mem_wdata;
            end

            if (state == S_IDLE)
                wcnt <= WAIT_INIT;
            else if (state == S_WAIT)
                wcnt <= wcnt - 4'd1;

            sram_en <= (state_nxt == S_ACCESS);
            sram_we <= (state_nxt == S_ACCESS) && src_we;
            if (state_nxt == S_ACCESS) begin
                sram_addr  <= src_addr;
                sram_wdata <= src_wdata;
            end

            mem_ready <= (state_nxt == S_RESP) || (state_nxt == S_ERR);
            mem_err   <= (state_nxt == S_ERR);

            if (state_nxt == S_ERR)
                rdata_q <= '0;
            else if (state == S_RESP && !lat_we)
                rdata_q <= sram_rdata;
        end
    end

    // SRAM data only arrives in the RESP cycle, so a load response is passed
    // straight through and then held by rdata_q.
    always_comb begin
        mem_rdata = rdata_q;
        if (state == S_RESP && !lat_we)
            mem_rdata = sram_rdata;
    end

`ifdef QAR_DMEM_BRIDGE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_reads  <= 16'd0;
            stat_writes <= 16'd0;
            stat_errs   <= 16'd0;
        end else begin
            if (state == S_RESP && !lat_we && stat_reads != 16'hFFFF)
                stat_reads <= stat_reads + 16'd1;
            if (state == S_RESP && lat_we && stat_writes != 16'hFFFF)
                stat_writes <= stat_writes + 16'd1;
            if (state == S_ERR && stat_errs != 16'hFFFF)
                stat_errs <= stat_errs + 16'd1;
        end
    end
`else
    assign stat_reads  = 16'd0;
    assign stat_writes = 16'd0;
    assign stat_errs   = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_qar_dmem_bridge.sv
// ============================================================================
// Module      : tb_qar_dmem_bridge
// Description : Self-checking bench for qar_dmem_bridge; three instances with
//               different wait states / base addresses share one clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qar_dmem_bridge;

    localparam int N     = 3;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst         [N];
    logic        mem_valid   [N];
    logic        mem_we      [N];
    logic [31:0] mem_addr    [N];
    logic [31:0] mem_wdata   [N];
    logic        mem_ready   [N];
    logic [31:0] mem_rdata   [N];
    logic        mem_err     [N];
    logic        sram_en     [N];
    logic        sram_we     [N];
    logic [7:0]  sram_addr   [N];
    logic [31:0] sram_wdata  [N];
    logic [31:0] sram_rdata  [N];
    logic [15:0] stat_reads  [N];
    logic [15:0] stat_writes [N];
    logic [15:0] stat_errs   [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        qar_dmem_bridge #(
            .DEPTH_WORDS (256),
            .SRAM_AW     (8),
            .BASE_ADDR   ((g == 2) ? 32'h0000_1000 : 32'h0000_0000),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 3 : 5))
        ) u_dut (
            .clk         (clk),
            .rst         (rst[g]),
            .mem_valid   (mem_valid[g]),
            .mem_we      (mem_we[g]),
            .mem_addr    (mem_addr[g]),
            .mem_wdata   (mem_wdata[g]),
            .mem_ready   (mem_ready[g]),
            .mem_rdata   (mem_rdata[g]),
            .mem_err     (mem_err[g]),
            .sram_en     (sram_en[g]),
            .sram_we     (sram_we[g]),
            .sram_addr   (sram_addr[g]),
            .sram_wdata  (sram_wdata[g]),
            .sram_rdata  (sram_rdata[g]),
            .stat_reads  (stat_reads[g]),
            .stat_writes (stat_writes[g]),
            .stat_errs   (stat_errs[g])
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 5);
    endfunction

    function automatic logic [31:0] base_of(input int k);
        return (k == 2) ? 32'h0000_1000 : 32'h0000_0000;
    endfunction

    function automatic logic [31:0] pat(input int k, input int i);
        return (32'h9E37_79B9 * 32'(i + 1)) ^ (32'(k) << 28);
    endfunction

    // Environment SRAM: 1-cycle synchronous read.
    logic        fill = 1'b0;
    logic [31:0] sram_mem [N][DEPTH];
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (fill) begin
                for (int i = 0; i < DEPTH; i++) sram_mem[k][i] <= pat(k, i);
            end else if (sram_en[k]) begin
                if (sram_we[k]) sram_mem[k][sram_addr[k]] <= sram_wdata[k];
                else            sram_rdata[k] <= sram_mem[k][sram_addr[k]];
            end
        end
    end

    int cyc_now = 0;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    // Reference model state
    logic [31:0] exp_mem  [N][DEPTH];
    logic [31:0] exp_last [N];
    int          exp_rd   [N];
    int          exp_wr   [N];
    int          exp_er   [N];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic bit is_bad(input int k, input logic [31:0] a);
        logic [31:0] b;
        b = base_of(k);
        if (a % 4 != 0) return 1'b1;
        if (a < b)      return 1'b1;
        return ((a - b) / 4) >= DEPTH;
    endfunction

    task automatic model_reset(input int k);
        exp_last[k] = 32'h0;
        exp_rd[k] = 0;
        exp_wr[k] = 0;
        exp_er[k] = 0;
    endtask

    task automatic reset_inst(input int k);
        mem_valid[k] = 1'b0;
        rst[k] = 1'b1;
        @(posedge clk); @(negedge clk);
        rst[k] = 1'b0;
        model_reset(k);
    endtask

    // Called at a negedge in an IDLE cycle (cycle 0); returns at the negedge
    // of the IDLE cycle following the response.
    task automatic do_req(input int k, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, output int t_ready);
        bit          bad, seen;
        int          exp_lat, ens;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_sa;
        bad       = is_bad(k, addr);
        exp_lat   = bad ? 1 : 2 + ws_of(k);
        exp_sa    = 8'((addr - base_of(k)) >> 2);
        exp_rdata = bad ? 32'h0 : (we ? exp_last[k] : exp_mem[k][exp_sa]);
        mem_valid[k] = 1'b1;
        mem_we[k]    = we;
        mem_addr[k]  = addr;
        mem_wdata[k] = wd;
        ens = 0; seen = 1'b0; t_ready = -1;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(posedge clk); @(negedge clk);
            if (sram_en[k]) begin
                ens++;
                if (!bad) begin
                    n_tests++;
                    if (c !== exp_lat - 1 || sram_we[k] !== we ||
                        sram_addr[k] !== exp_sa || sram_wdata[k] !== wd) begin
                        n_fail++;
                        $display("FAIL sram_access k=%0d addr=%h: cyc=%0d we=%b sa=%h wd=%h, want cyc=%0d we=%b sa=%h wd=%h",
                                 k, addr, c, sram_we[k], sram_addr[k], sram_wdata[k], exp_lat - 1, we, exp_sa, wd);
                    end
                end
            end
            if (mem_ready[k]) begin
                seen = 1'b1;
                t_ready = cyc_now;
                n_tests++;
                if (c !== exp_lat || mem_err[k] !== bad || mem_rdata[k] !== exp_rdata) begin
                    n_fail++;
                    $display("FAIL response k=%0d addr=%h we=%b: cyc=%0d err=%b rdata=%h, want cyc=%0d err=%b rdata=%h",
                             k, addr, we, c, mem_err[k], mem_rdata[k], exp_lat, bad, exp_rdata);
                end
            end
            if (c == 1) begin
                mem_addr[k]  = $urandom;
                mem_wdata[k] = $urandom;
                mem_we[k]    = 1'($urandom);
            end
        end
        if (!seen) begin
            n_fail++;
            $display("FAIL ready_timeout k=%0d addr=%h: no mem_ready in 40 cycles, want cycle %0d", k, addr, exp_lat);
        end
        n_tests++;
        if (ens !== (bad ? 0 : 1)) begin
            n_fail++;
            $display("FAIL sram_en_count k=%0d addr=%h: got %0d pulses, want %0d", k, addr, ens, bad ? 0 : 1);
        end
        if (bad) begin
            exp_last[k] = 32'h0;
            exp_er[k]++;
        end else if (we) begin
            exp_mem[k][exp_sa] = wd;
            exp_wr[k]++;
        end else begin
            exp_last[k] = exp_mem[k][exp_sa];
            exp_rd[k]++;
        end
        mem_valid[k] = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic check_idle_outputs(input int k, input string tag);
        n_tests++;
        if (mem_ready[k] !== 1'b0 || mem_err[k] !== 1'b0 || mem_rdata[k] !== 32'h0 ||
            sram_en[k] !== 1'b0 || sram_we[k] !== 1'b0 || sram_addr[k] !== 8'h0 ||
            sram_wdata[k] !== 32'h0 || stat_reads[k] !== 16'h0 ||
            stat_writes[k] !== 16'h0 || stat_errs[k] !== 16'h0) begin
            n_fail++;
            $display("FAIL %s k=%0d: rdy=%b err=%b rd=%h en=%b we=%b sa=%h wd=%h st=%0d/%0d/%0d, want all zero",
                     tag, k, mem_ready[k], mem_err[k], mem_rdata[k], sram_en[k], sram_we[k],
                     sram_addr[k], sram_wdata[k], stat_reads[k], stat_writes[k], stat_errs[k]);
        end
    endtask

    task automatic check_stats(input int k, input int r, input int w, input int e);
        int xr, xw, xe;
`ifdef QAR_DMEM_BRIDGE_STATS_EN
        xr = r; xw = w; xe = e;
`else
        xr = 0 * r; xw = 0 * w; xe = 0 * e;
`endif
        n_tests++;
        if (stat_reads[k] !== 16'(xr) || stat_writes[k] !== 16'(xw) || stat_errs[k] !== 16'(xe)) begin
            n_fail++;
            $display("FAIL stats k=%0d: got r/w/e=%0d/%0d/%0d, want %0d/%0d/%0d",
                     k, stat_reads[k], stat_writes[k], stat_errs[k], xr, xw, xe);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1; mem_valid[k] = 1'b0; mem_we[k] = 1'b0;
            mem_addr[k] = 32'h0; mem_wdata[k] = 32'h0;
        end
        fill = 1'b1;
        @(posedge clk); @(negedge clk);
        fill = 1'b0;
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < N; k++) check_idle_outputs(k, "reset_state");
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b0;
            model_reset(k);
            for (int i = 0; i < DEPTH; i++) exp_mem[k][i] = pat(k, i);
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_basic();
        int t;
        do_req(0, 1'b1, 32'h40, 32'hDEAD_BEEF, t);
        do_req(0, 1'b0, 32'h40, 32'h0, t);
        n_tests++;
        if (exp_last[0] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL basic_roundtrip: model holds %h, want deadbeef", exp_last[0]);
        end
    endtask

    task automatic test_wait();
        int t;
        do_req(1, 1'b0, 32'h3FC, 32'h0, t);
        do_req(1, 1'b1, 32'h3FC, 32'h1234_5678, t);
        do_req(1, 1'b0, 32'h3FC, 32'h0, t);
    endtask

    task automatic test_errors();
        int t;
        do_req(0, 1'b0, 32'h3FC, 32'h0, t);
        do_req(0, 1'b1, 32'h400, 32'hBAD0_BAD0, t);
        do_req(0, 1'b0, 32'h002, 32'h0, t);
        do_req(0, 1'b0, 32'h3FC, 32'h0, t);
        do_req(2, 1'b0, 32'h0FFC, 32'h0, t);
        do_req(2, 1'b0, 32'h13FC, 32'h0, t);
        do_req(2, 1'b1, 32'h1400, 32'h5555_AAAA, t);
    endtask

    task automatic test_back_to_back();
        int t0, t1, t2, t3;
        t0 = cyc_now;
        do_req(0, 1'b0, 32'h00, 32'h0, t1);
        do_req(0, 1'b0, 32'h04, 32'h0, t2);
        do_req(0, 1'b0, 32'h08, 32'h0, t3);
        n_tests++;
        if (t1 - t0 !== 2 || t2 - t0 !== 5 || t3 - t0 !== 8) begin
            n_fail++;
            $display("FAIL back_to_back: ready at %0d,%0d,%0d, want 2,5,8", t1 - t0, t2 - t0, t3 - t0);
        end
    endtask

    task automatic test_rst_mid();
        int t, bad_cnt;
        bad_cnt = 0;
        mem_valid[2] = 1'b1; mem_we[2] = 1'b1;
        mem_addr[2] = 32'h1020; mem_wdata[2] = 32'hFEED_F00D;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); @(negedge clk);
            if (mem_ready[2] || sram_en[2]) bad_cnt++;
        end
        rst[2] = 1'b1; mem_valid[2] = 1'b0;
        @(posedge clk); @(negedge clk);
        rst[2] = 1'b0;
        check_idle_outputs(2, "reset_mid_wait");
        model_reset(2);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); @(negedge clk);
            if (mem_ready[2] || sram_en[2]) bad_cnt++;
        end
        n_tests++;
        if (bad_cnt !== 0) begin
            n_fail++;
            $display("FAIL rst_drop: %0d cycles with ready/sram_en, want 0", bad_cnt);
        end
        do_req(2, 1'b0, 32'h1020, 32'h0, t);
        do_req(2, 1'b1, 32'h1024, 32'h0BAD_CAFE, t);
        do_req(2, 1'b0, 32'h1024, 32'h0, t);
    endtask

    task automatic test_random();
        int t, r;
        logic [31:0] a, b;
        for (int k = 1; k < N; k++) begin
            b = base_of(k);
            for (int n = 0; n < 25; n++) begin
                r = $urandom_range(0, 9);
                if (r < 6)       a = b + 32'(4 * $urandom_range(0, 255));
                else if (r < 8)  a = b + 32'(4 * $urandom_range(0, 255)) + 32'($urandom_range(1, 3));
                else if (r == 8) a = b + 32'(4 * (256 + $urandom_range(0, 1000)));
                else             a = (k == 2) ? b - 32'(4 * $urandom_range(1, 16)) : $urandom;
                do_req(k, 1'($urandom), a, $urandom, t);
            end
        end
    endtask

    task automatic test_stats();
        int t;
        reset_inst(0);
        do_req(0, 1'b0, 32'h10, 32'h0, t);
        do_req(0, 1'b1, 32'h14, 32'hCAFE_0001, t);
        do_req(0, 1'b0, 32'h14, 32'h0, t);
        do_req(0, 1'b0, 32'h11, 32'h0, t);
        check_stats(0, 2, 1, 1);
        for (int k = 0; k < N; k++) check_stats(k, exp_rd[k], exp_wr[k], exp_er[k]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wait();
        test_errors();
        test_back_to_back();
        test_rst_mid();
        test_random();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
